// File: rtl/multicycle_control_unit_if.sv
// Bus between the multicycle control unit and its datapath.
// The master side is the control unit: it reads Opcode/Funct/Zero/MemReady
// from the instruction register, ALU and memory, and drives every control
// line, the exported State code, the Illegal pulse and the retired count.
// The slave side is the datapath (or a bench standing in for it).
interface multicycle_control_unit_if #(
  parameter int ALUCTRL_WIDTH = 4,
  parameter int RETIRE_WIDTH  = 32,
  parameter int STATE_WIDTH   = 4
);
  logic [5:0]               Opcode;
  logic [5:0]               Funct;
  logic                     Zero;
  logic                     MemReady;
  logic                     IorD;
  logic                     MemRead;
  logic                     MemWrite;
  logic                     IRWrite;
  logic                     RegDst;
  logic                     MemtoReg;
  logic                     RegWrite;
  logic                     ALUSrcA;
  logic [1:0]               ALUSrcB;
  logic [1:0]               PCSrc;
  logic                     PCEn;
  logic [ALUCTRL_WIDTH-1:0] ALUControl;
  logic [STATE_WIDTH-1:0]   State;
  logic                     Illegal;
  logic [RETIRE_WIDTH-1:0]  InstrRetired;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUControl, State, Illegal, InstrRetired
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUControl, State, Illegal, InstrRetired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: a Moore FSM stepping fetch, decode, execute,
// memory and writeback for R-type, lw, sw, beq, addi and j.
// Ports: CLK (rising edge), Reset (synchronous, active-low), bus (master
// modport of multicycle_control_unit_if carrying Opcode/Funct/Zero/MemReady
// in and all datapath controls, State, Illegal and InstrRetired out).
// State-decoded controls are registered: they are computed from the next
// state and loaded together with it. IRWrite, PCEn, Illegal and the EXECUTE
// ALUControl depend on live inputs and are decoded from the current state.
module multicycle_control_unit #(
  parameter int ALUCTRL_WIDTH = 4,
  parameter int RETIRE_WIDTH  = 32,
  parameter int STATE_WIDTH   = 4
) (
  input logic                      CLK,
  input logic                      Reset,
  multicycle_control_unit_if.master bus
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR  = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,  S_EXECUTE = 4'd6,  S_ALUWB   = 4'd7,
    S_BRANCH   = 4'd8,  S_ADDIEXEC = 4'd9,  S_ADDIWB  = 4'd10, S_JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       branch;
    logic [3:0] alu_op;
  } ctrl_t;

  // Pure state decode of the Moore controls; anything not listed stays 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = ALU_ADD; end
      S_DECODE:   begin c.alu_src_b = 2'b11; c.alu_op = ALU_ADD; end
      S_MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = ALU_ADD; end
      S_MEMREAD:  begin c.iord = 1'b1; c.mem_read = 1'b1; end
      S_MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; end
      S_ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.branch = 1'b1; c.pc_src = 2'b01; end
      S_ADDIEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = ALU_ADD; end
      S_ADDIWB:   begin c.reg_write = 1'b1; end
      S_JUMP:     begin c.pc_src = 2'b10; end
      default:    begin c = '0; end
    endcase
    return c;
  endfunction

  // Returns {known, alu_op}; unknown functs fall back to ADD.
  function automatic logic [4:0] funct_decode(input logic [5:0] f);
    logic [4:0] r;
    case (f)
      6'b100000: r = {1'b1, ALU_ADD};
      6'b100010: r = {1'b1, ALU_SUB};
      6'b100100: r = {1'b1, ALU_AND};
      6'b100101: r = {1'b1, ALU_OR};
      6'b101010: r = {1'b1, ALU_SLT};
      6'b100111: r = {1'b1, ALU_NOR};
      default:   r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

  state_t                  state_r;
  state_t                  next_state_s;
  ctrl_t                   ctrl_r;
  logic [RETIRE_WIDTH-1:0] retired_r;
  logic [4:0]              funct_info_s;
  logic                    retire_s;
  logic                    illegal_s;
  logic                    pc_write_s;

  assign funct_info_s = funct_decode(bus.Funct);

  // Next-state selection from the current state and the live inputs.
  always_comb begin
    next_state_s = S_FETCH;
    illegal_s    = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (bus.MemReady) next_state_s = S_DECODE;
        else              next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_EXECUTE;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_ADDI:      next_state_s = S_ADDIEXEC;
          OP_J:         next_state_s = S_JUMP;
          default: begin
            next_state_s = S_FETCH;
            illegal_s    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (bus.Opcode == OP_LW)      next_state_s = S_MEMREAD;
        else if (bus.Opcode == OP_SW) next_state_s = S_MEMWRITE;
        else                          next_state_s = S_FETCH;
      end
      S_MEMREAD: begin
        if (bus.MemReady) next_state_s = S_MEMWB;
        else              next_state_s = S_MEMREAD;
      end
      S_MEMWRITE: begin
        // A store retires in the cycle memory accepts it.
        if (bus.MemReady) begin
          next_state_s = S_FETCH;
          retire_s     = 1'b1;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_EXECUTE: begin
        if (funct_info_s[4]) begin
          next_state_s = S_ALUWB;
        end else begin
          next_state_s = S_FETCH;
          illegal_s    = 1'b1;
        end
      end
      S_ADDIEXEC: next_state_s = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        next_state_s = S_FETCH;
        retire_s     = 1'b1;
      end
      default: next_state_s = S_FETCH;
    endcase
  end

  // State register, registered controls and retired-instruction counter.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_r   <= S_FETCH;
      ctrl_r    <= state_ctrl(S_FETCH);
      retired_r <= '0;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= state_ctrl(next_state_s);
      if (retire_s) retired_r <= retired_r + {{(RETIRE_WIDTH-1){1'b0}}, 1'b1};
      else          retired_r <= retired_r;
    end
  end

  // PC loads on a completed fetch or a jump; beq adds the Zero-qualified path.
  assign pc_write_s = ((state_r == S_FETCH) & bus.MemReady) | (state_r == S_JUMP);

  assign bus.IorD         = ctrl_r.iord;
  assign bus.MemRead      = ctrl_r.mem_read;
  assign bus.MemWrite     = ctrl_r.mem_write;
  assign bus.IRWrite      = (state_r == S_FETCH) & bus.MemReady;
  assign bus.RegDst       = ctrl_r.reg_dst;
  assign bus.MemtoReg     = ctrl_r.mem_to_reg;
  assign bus.RegWrite     = ctrl_r.reg_write;
  assign bus.ALUSrcA      = ctrl_r.alu_src_a;
  assign bus.ALUSrcB      = ctrl_r.alu_src_b;
  assign bus.PCSrc        = ctrl_r.pc_src;
  assign bus.PCEn         = pc_write_s | (ctrl_r.branch & bus.Zero);
  assign bus.ALUControl   = (state_r == S_EXECUTE) ? ALUCTRL_WIDTH'(funct_info_s[3:0])
                                                   : ALUCTRL_WIDTH'(ctrl_r.alu_op);
  assign bus.State        = STATE_WIDTH'(state_r);
  assign bus.Illegal      = illegal_s;
  assign bus.InstrRetired = retired_r;

endmodule
